// File: rtl/mac_sequencer_pkg.sv
// Shared types and constants for the dot-product sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mac_sequencer_pkg;

    localparam int MAC_W      = 32;
    localparam int DEF_ADDR_W = 8;
    localparam int DEF_LEN_W  = 8;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_FETCH   = 3'd1,
        S_DRAIN   = 3'd2,
        S_CAPTURE = 3'd3,
        S_HOLD    = 3'd4
    } state_t;

endpackage

// File: rtl/mac_sequencer_addr_gen.sv
// Element counter and A/B operand address generator for one dot-product command.
// Latency: addresses are combinational from registered base/offset; update on each adv.
// Backpressure: none; advances only when the sequencer pulses adv.
module mac_addr_gen
    import mac_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic              adv,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] b_stride,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    output logic              first,
    output logic              last
);

    logic [LEN_W-1:0]  len_q;
    logic [LEN_W-1:0]  i_q;
    logic [ADDR_W-1:0] a_base_q;
    logic [ADDR_W-1:0] b_base_q;
    logic [ADDR_W-1:0] stride_q;
    // Running i*stride kept as an accumulated offset so no multiplier is needed.
    logic [ADDR_W-1:0] b_off_q;

    // Latch the command on load, then step counter and B offset once per element.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_q    <= '0;
            i_q      <= '0;
            a_base_q <= '0;
            b_base_q <= '0;
            stride_q <= '0;
            b_off_q  <= '0;
        end else if (load) begin
            len_q    <= len;
            i_q      <= '0;
            a_base_q <= a_base;
            b_base_q <= b_base;
            stride_q <= b_stride;
            b_off_q  <= '0;
        end else if (adv) begin
            i_q     <= i_q + 1'b1;
            b_off_q <= b_off_q + stride_q;
        end
    end

    // Address sums truncate naturally, giving modulo 2^ADDR_W wrap.
    assign a_addr = a_base_q + ADDR_W'(i_q);
    assign b_addr = b_base_q + b_off_q;
    assign first  = (i_q == '0);
    assign last   = (i_q == len_q - 1'b1);

endmodule

// File: rtl/mac_sequencer.sv
// Sequences operand fetch into the MAC core and captures one dot product per command.
// Latency: start at edge 0 -> result_valid in cycle len+3 (cycle 1 for len=0).
// Backpressure: result held in HOLD until result_ready; start ignored unless idle.
module mac_sequencer
    import mac_sequencer_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int LEN_W  = DEF_LEN_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [LEN_W-1:0]  len,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] b_base,
    input  logic [ADDR_W-1:0] b_stride,
    output logic              rd_en,
    output logic [ADDR_W-1:0] a_addr,
    output logic [ADDR_W-1:0] b_addr,
    input  logic [MAC_W-1:0]  a_rdata,
    input  logic [MAC_W-1:0]  b_rdata,
    output logic              mac_run,
    output logic              mac_first,
    output logic [MAC_W-1:0]  mac_a,
    output logic [MAC_W-1:0]  mac_b,
    input  logic [MAC_W-1:0]  mac_acc,
    output logic              busy,
    output logic [MAC_W-1:0]  result,
    output logic              result_valid,
    input  logic              result_ready
);

    state_t            state_q, state_n;
    logic              ag_load, ag_adv, ag_first, ag_last;
    logic [ADDR_W-1:0] ag_a_addr, ag_b_addr;
    logic              v_q, f_q;
    logic              busy_q;
    logic              res_clr, res_cap;
    logic [MAC_W-1:0]  result_q;

    mac_addr_gen #(
        .ADDR_W (ADDR_W),
        .LEN_W  (LEN_W)
    ) u_addr_gen (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (ag_load),
        .adv      (ag_adv),
        .len      (len),
        .a_base   (a_base),
        .b_base   (b_base),
        .b_stride (b_stride),
        .a_addr   (ag_a_addr),
        .b_addr   (ag_b_addr),
        .first    (ag_first),
        .last     (ag_last)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_n;
    end

    // Next-state logic plus the strobes that drive the address generator and result register.
    always_comb begin
        state_n = state_q;
        ag_load = 1'b0;
        ag_adv  = 1'b0;
        res_clr = 1'b0;
        res_cap = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        ag_load = 1'b1;
                        state_n = S_FETCH;
                    end else begin
                        res_clr = 1'b1;
                        state_n = S_HOLD;
                    end
                end
            end
            S_FETCH: begin
                ag_adv = 1'b1;
                if (ag_last) state_n = S_DRAIN;
            end
            S_DRAIN:   state_n = S_CAPTURE;
            S_CAPTURE: begin
                res_cap = 1'b1;
                state_n = S_HOLD;
            end
            S_HOLD: begin
                if (result_ready) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Data stage: valid/first follow the read strobe by one cycle to match memory latency.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v_q <= 1'b0;
            f_q <= 1'b0;
        end else begin
            v_q <= rd_en;
            f_q <= rd_en & ag_first;
        end
    end

    // busy covers FETCH..CAPTURE and the first HOLD cycle after a real (len>0) command.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy_q <= 1'b0;
        else        busy_q <= (state_n == S_FETCH) || (state_n == S_DRAIN) ||
                              (state_n == S_CAPTURE) || (state_q == S_CAPTURE);
    end

    // Result capture: zero for empty commands, MAC accumulator after the last element lands.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)       result_q <= '0;
        else if (res_clr) result_q <= '0;
        else if (res_cap) result_q <= mac_acc;
    end

    assign rd_en        = (state_q == S_FETCH);
    assign a_addr       = rd_en ? ag_a_addr : '0;
    assign b_addr       = rd_en ? ag_b_addr : '0;
    assign mac_run      = v_q;
    assign mac_first    = f_q & v_q;
    assign mac_a        = v_q ? a_rdata : '0;
    assign mac_b        = v_q ? b_rdata : '0;
    assign busy         = busy_q;
    assign result       = result_q;
    assign result_valid = (state_q == S_HOLD);

endmodule

// File: doc/mac_sequencer.md
Name: mac_sequencer

Overview:
- Initiator that drives the 32-bit multiply-accumulate core (run / first / a / b in, acc out).
- Computes one dot product per command: fetches A[i] and B[i] from two synchronous-read operand memories, streams them into the MAC, then captures the accumulated result.
- Holds the result behind a valid/ready handshake for the bus-side register file.
- Sits between the accelerator register block and the MAC core.

Parameters:
ADDR_W, 8, operand memory address width
LEN_W, 8, width of the element-count field

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
start  input  1  one-cycle command strobe; ignored unless idle
len  input  LEN_W  number of elements to accumulate; sampled on start
a_base  input  ADDR_W  first A address; sampled on start
b_base  input  ADDR_W  first B address; sampled on start
b_stride  input  ADDR_W  B address increment per element (1 = row, N = column); sampled on start
rd_en  output  1  read strobe to both operand memories
a_addr  output  ADDR_W  A memory address
b_addr  output  ADDR_W  B memory address
a_rdata  input  32  A data, valid the cycle after rd_en
b_rdata  input  32  B data, valid the cycle after rd_en
mac_run  output  1  MAC enable; MAC clears acc when low
mac_first  output  1  MAC load (acc <= a*b) instead of accumulate
mac_a  output  32  MAC operand a
mac_b  output  32  MAC operand b
mac_acc  input  32  MAC accumulator, registered in the MAC
busy  output  1  high from the cycle after an accepted start until result_valid
result  output  32  captured dot product
result_valid  output  1  result available
result_ready  input  1  consumer accepts result

Behaviour:
- Reset (async assert, sync release): state IDLE; rd_en, mac_run, mac_first, busy and result_valid are 0; a_addr, b_addr, mac_a, mac_b and result are 0. Reset mid-operation abandons the command and discards any held result.
- FSM states: IDLE, FETCH, DRAIN, CAPTURE, HOLD.
- IDLE:
  - start=1 with len>0: latch len, a_base, b_base and b_stride, clear element counter i, go to FETCH.
  - start=1 with len=0: result<=0, go to HOLD.
- FETCH (cycles 1..L):
  - rd_en=1, a_addr=a_base+i, b_addr=b_base+i*b_stride.
  - Addresses wrap modulo 2^ADDR_W; i increments every cycle.
  - After the read with i=L-1 is issued, go to DRAIN.
- Data stage (registered valid bit v and first bit f, driven one cycle behind rd_en):
  - mac_run=v, mac_first=f&v.
  - mac_a=a_rdata and mac_b=b_rdata when v=1, else 0.
  - f is high only for element 0.
  - Operands reach the MAC in cycles 2..L+1.
- DRAIN: one cycle, the last data stage. Go to CAPTURE.
- CAPTURE: mac_run=0. result<=mac_acc, which holds sum(A[i]*B[i]) mod 2^32 (unsigned, truncated). Go to HOLD.
- HOLD:
  - result_valid=1; result stays stable until result_ready=1.
  - Transfer completes on result_valid&result_ready; next state is IDLE.
  - result_valid stays high for the remainder of the transfer cycle and clears on the following edge.
  - A start coinciding with the transfer cycle is ignored.
- Latency: start sampled at edge 0, result_valid first high in cycle L+3 (len=0: cycle 1).
- busy=1 in FETCH, DRAIN and CAPTURE; it is also 1 in the first HOLD cycle for len>0; it is 0 in IDLE. start while busy or in HOLD is ignored, with no queueing.
- Throughput: one element per cycle, no bubbles within a command.

Decomposition:
- Shared package:
  - FSM state enum (3-bit).
  - MAC data width constant (32).
  - Default ADDR_W and LEN_W.
- Sub-module: mac_addr_gen, holding the element counter and the a/b address generation (base, stride, wrap, last-element flag).
- The MAC core itself is instantiated by the parent, not inside this block.

Test Plan:
- len=3, a_base=0, b_base=0x10, b_stride=4, A={2,3,4}, B@0x10/0x14/0x18={5,6,7} -> a_addr 0,1,2; b_addr 0x10,0x14,0x18; mac_first only on the first element; result=56 with result_valid in cycle 6.
- len=0 -> no rd_en pulse; result=0, result_valid in cycle 1.
- A={0xFFFFFFFF,2}, B={2,0x80000000}, len=2 -> result=0xFFFFFFFE (mod 2^32 wrap).
- result_ready held low 10 cycles after valid; second start pulsed meanwhile -> result stable, start ignored, no rd_en; accept -> IDLE.
- b_base=0xFE, b_stride=1, len=4 -> b_addr 0xFE, 0xFF, 0x00, 0x01.
- rst_n low during FETCH of a len=8 command -> all outputs 0 immediately; a fresh len=1 command (A=7, B=9) then returns result=9*7=63.
